ex_mem_stage: RTL

Pipeline stage directly downstream of the 16-bit ALU. It is the EX→MEM boundary of the processor datapath. Each cycle it takes the ALU result, the ALU flags (Zero, Ofl, Carry, Neg) and the execute-stage control bits. It resolves set-condition results, selects link values, and registers everything into a single-entry stage with a valid/ready handshake, flush and sticky halt. It also drives a registered forwarding port back to execute.

---
 rtl/ex_mem_stage_pkg.sv | 26 ++
 rtl/ex_mem_stage_if.sv | 51 +++++
 rtl/ex_mem_stage_cond_resolve.sv | 31 +++
 rtl/ex_mem_stage.sv | 69 ++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM boundary: datapath widths, result-select
// encodings (also used by execute-stage decode) and the held-entry layout.
package ex_mem_stage_pkg;

  localparam int N = 16;
  localparam int R = 3;

  typedef enum logic [2:0] {
    RES_ALU  = 3'd0,
    RES_SEQ  = 3'd1,
    RES_SLT  = 3'd2,
    RES_SLE  = 3'd3,
    RES_SCO  = 3'd4,
    RES_LINK = 3'd5
  } res_sel_e;

  typedef struct packed {
    logic [N-1:0] result;
    logic [N-1:0] st_data;
    logic         mem_rd;
    logic         mem_wr;
    logic         reg_wr;
    logic [R-1:0] wr_reg;
  } entry_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Execute-side inputs, MEM-side outputs and the forwarding port of the EX->MEM stage.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// valid never depends on ready, and ready never depends on the same side's valid.
interface ex_mem_stage_if;
  import ex_mem_stage_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] alu_out;
  logic         zero;
  logic         ofl;
  logic         carry;
  logic         neg;
  logic [2:0]   res_sel;
  logic [N-1:0] link_pc;
  logic [N-1:0] st_data;
  logic         mem_rd;
  logic         mem_wr;
  logic         reg_wr;
  logic         halt_in;
  logic [R-1:0] wr_reg;
  logic         flush;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [N-1:0] st_data_q;
  logic         mem_rd_q;
  logic         mem_wr_q;
  logic         reg_wr_q;
  logic [R-1:0] wr_reg_q;
  logic         fwd_en;
  logic [R-1:0] fwd_reg;
  logic [N-1:0] fwd_data;
  logic         halted;

  modport master (
    output in_valid, alu_out, zero, ofl, carry, neg, res_sel, link_pc, st_data,
           mem_rd, mem_wr, reg_wr, halt_in, wr_reg, flush, out_ready,
    input  in_ready, out_valid, result, st_data_q, mem_rd_q, mem_wr_q, reg_wr_q,
           wr_reg_q, fwd_en, fwd_reg, fwd_data, halted
  );

  modport slave (
    input  in_valid, alu_out, zero, ofl, carry, neg, res_sel, link_pc, st_data,
           mem_rd, mem_wr, reg_wr, halt_in, wr_reg, flush, out_ready,
    output in_ready, out_valid, result, st_data_q, mem_rd_q, mem_wr_q, reg_wr_q,
           wr_reg_q, fwd_en, fwd_reg, fwd_data, halted
  );

endinterface

// File: rtl/ex_mem_stage_cond_resolve.sv
// Turns ALU flags into set-condition results and selects link/ALU values.
// Set compares assume the ALU computed A-B (or A+B for SCO).
module ex_mem_stage_cond_resolve
  import ex_mem_stage_pkg::*;
(
  input  logic         zero,
  input  logic         ofl,
  input  logic         carry,
  input  logic         neg,
  input  logic [2:0]   res_sel,
  input  logic [N-1:0] alu_out,
  input  logic [N-1:0] link_pc,
  output logic [N-1:0] result
);

  logic lt;
  assign lt = neg ^ ofl;

  always_comb begin
    result = alu_out;
    case (res_sel)
      RES_SEQ:  result = {{(N-1){1'b0}}, zero};
      RES_SLT:  result = {{(N-1){1'b0}}, lt};
      RES_SLE:  result = {{(N-1){1'b0}}, lt | zero};
      RES_SCO:  result = {{(N-1){1'b0}}, carry};
      RES_LINK: result = link_pc;
      default:  result = alu_out;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: single-entry valid/ready stage with flush, sticky
// halt and a registered forwarding port back to execute.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ex_mem_stage_if.slave bus
);

  entry_t       q;
  logic         out_valid;
  logic         halted;
  logic         in_ready;
  logic         accept;
  logic [N-1:0] res_next;

  ex_mem_stage_cond_resolve u_cond (
    .zero    (bus.zero),
    .ofl     (bus.ofl),
    .carry   (bus.carry),
    .neg     (bus.neg),
    .res_sel (bus.res_sel),
    .alu_out (bus.alu_out),
    .link_pc (bus.link_pc),
    .result  (res_next)
  );

  assign in_ready = ~halted & (~out_valid | bus.out_ready);
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  // Flush beats accept, accept beats drain, so a drain+accept keeps out_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      q.result  <= res_next;
      q.st_data <= bus.st_data;
      q.mem_rd  <= bus.mem_rd;
      q.mem_wr  <= bus.mem_wr;
      q.reg_wr  <= bus.reg_wr;
      q.wr_reg  <= bus.wr_reg;
      out_valid <= 1'b1;
      if (bus.halt_in) halted <= 1'b1;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.halted    = halted;
  assign bus.result    = q.result;
  assign bus.st_data_q = q.st_data;
  assign bus.wr_reg_q  = q.wr_reg;
  assign bus.mem_rd_q  = out_valid & q.mem_rd;
  assign bus.mem_wr_q  = out_valid & q.mem_wr;
  assign bus.reg_wr_q  = out_valid & q.reg_wr;

  // Loads are not forwardable: their data only exists after MEM.
  assign bus.fwd_en    = out_valid & q.reg_wr & ~q.mem_rd;
  assign bus.fwd_reg   = q.wr_reg;
  assign bus.fwd_data  = q.result;

endmodule
